// File: rtl/skin_map_reader.sv
// Scans a 40x30 skin-patch map one patch per clock; publishes count, bounding box and sums.
// Optional macro NEIGHBOUR_FILTER_EN: a patch counts only if a 4-neighbour is also set.
module skin_map_reader (
  input  logic          clk,
  input  logic          rst,
  input  logic          iStart,
  input  logic [1199:0] iSkinFrame,
  output logic          oBusy,
  output logic          oDone,
  output logic          oValid,
  output logic [10:0]   oCount,
  output logic [5:0]    oMinX,
  output logic [5:0]    oMaxX,
  output logic [5:0]    oMinY,
  output logic [5:0]    oMaxY,
  output logic [15:0]   oSumX,
  output logic [15:0]   oSumY
);

  localparam int unsigned Cols    = 40;
  localparam int unsigned Patches = 1200;

  typedef enum logic [1:0] {StIdle, StScan, StPublish} state_e;

  state_e state_q, state_d;

  // Shadow shifts right each scan step, so bit 0 is always the current patch.
  logic [Patches-1:0] shadow_q;
  logic [10:0]        idx_q;
  logic [5:0]         x_q;
  logic [5:0]         y_q;

  logic [10:0] count_q;
  logic [15:0] sum_x_q;
  logic [15:0] sum_y_q;
  logic [5:0]  min_x_q;
  logic [5:0]  max_x_q;
  logic [5:0]  min_y_q;
  logic [5:0]  max_y_q;

  logic        res_valid_q;
  logic [10:0] res_count_q;
  logic [5:0]  res_min_x_q;
  logic [5:0]  res_max_x_q;
  logic [5:0]  res_min_y_q;
  logic [5:0]  res_max_y_q;
  logic [15:0] res_sum_x_q;
  logic [15:0] res_sum_y_q;
  logic        done_q;

  logic hit;

`ifdef NEIGHBOUR_FILTER_EN
  // Last 40 patches shifted out: bit 39 is the left neighbour, bit 0 the one above.
  logic [Cols-1:0] hist_q;
  logic            nb_left;
  logic            nb_right;
  logic            nb_up;
  logic            nb_down;

  always_comb begin
    nb_left  = hist_q[Cols-1] & (x_q != 6'd0);
    nb_right = shadow_q[1] & (x_q != 6'd39);
    nb_up    = hist_q[0] & (y_q != 6'd0);
    nb_down  = shadow_q[Cols] & (y_q != 6'd29);
    hit      = shadow_q[0] & (nb_left | nb_right | nb_up | nb_down);
  end
`else
  always_comb begin
    hit = shadow_q[0];
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (iStart) state_d = StScan;
      StScan:    if (idx_q == 11'(Patches - 1)) state_d = StPublish;
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      count_q     <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      min_x_q     <= '0;
      max_x_q     <= '0;
      min_y_q     <= '0;
      max_y_q     <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_min_x_q <= '0;
      res_max_x_q <= '0;
      res_min_y_q <= '0;
      res_max_y_q <= '0;
      res_sum_x_q <= '0;
      res_sum_y_q <= '0;
      done_q      <= 1'b0;
`ifdef NEIGHBOUR_FILTER_EN
      hist_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            shadow_q <= iSkinFrame;
            idx_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            count_q  <= '0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            min_x_q  <= 6'd63;
            max_x_q  <= '0;
            min_y_q  <= 6'd63;
            max_y_q  <= '0;
`ifdef NEIGHBOUR_FILTER_EN
            hist_q   <= '0;
`endif
          end
        end
        StScan: begin
          shadow_q <= {1'b0, shadow_q[Patches-1:1]};
`ifdef NEIGHBOUR_FILTER_EN
          hist_q   <= {shadow_q[0], hist_q[Cols-1:1]};
`endif
          if (hit) begin
            count_q <= count_q + 11'd1;
            sum_x_q <= sum_x_q + {10'd0, x_q};
            sum_y_q <= sum_y_q + {10'd0, y_q};
            if (x_q < min_x_q) min_x_q <= x_q;
            if (x_q > max_x_q) max_x_q <= x_q;
            if (y_q < min_y_q) min_y_q <= y_q;
            if (y_q > max_y_q) max_y_q <= y_q;
          end
          idx_q <= idx_q + 11'd1;
          if (x_q == 6'(Cols - 1)) begin
            x_q <= '0;
            y_q <= y_q + 6'd1;
          end else begin
            x_q <= x_q + 6'd1;
          end
        end
        StPublish: begin
          res_valid_q <= (count_q != 11'd0);
          res_count_q <= count_q;
          res_sum_x_q <= sum_x_q;
          res_sum_y_q <= sum_y_q;
          if (count_q == 11'd0) begin
            res_min_x_q <= '0;
            res_max_x_q <= '0;
            res_min_y_q <= '0;
            res_max_y_q <= '0;
          end else begin
            res_min_x_q <= min_x_q;
            res_max_x_q <= max_x_q;
            res_min_y_q <= min_y_q;
            res_max_y_q <= max_y_q;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oBusy  = (state_q != StIdle);
  assign oDone  = done_q;
  assign oValid = res_valid_q;
  assign oCount = res_count_q;
  assign oMinX  = res_min_x_q;
  assign oMaxX  = res_max_x_q;
  assign oMinY  = res_min_y_q;
  assign oMaxY  = res_max_y_q;
  assign oSumX  = res_sum_x_q;
  assign oSumY  = res_sum_y_q;

endmodule

// File: tb/tb_skin_map_reader.sv
// Randomized self-checking bench for skin_map_reader against a behavioural scan model.
// Honours NEIGHBOUR_FILTER_EN the same way as the design.
module tb_skin_map_reader;

  typedef struct packed {
    logic        valid;
    logic [10:0] count;
    logic [5:0]  min_x;
    logic [5:0]  max_x;
    logic [5:0]  min_y;
    logic [5:0]  max_y;
    logic [15:0] sum_x;
    logic [15:0] sum_y;
  } res_t;

`ifdef NEIGHBOUR_FILTER_EN
  localparam bit Filt = 1'b1;
`else
  localparam bit Filt = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1199:0] frame = '0;
  logic          busy, done, valid;
  logic [10:0]   count;
  logic [5:0]    min_x, max_x, min_y, max_y;
  logic [15:0]   sum_x, sum_y;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  skin_map_reader dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (start),
    .iSkinFrame(frame),
    .oBusy     (busy),
    .oDone     (done),
    .oValid    (valid),
    .oCount    (count),
    .oMinX     (min_x),
    .oMaxX     (max_x),
    .oMinY     (min_y),
    .oMaxY     (max_y),
    .oSumX     (sum_x),
    .oSumY     (sum_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result straight from the patch-counting rules.
  function automatic res_t compute(input logic [1199:0] m);
    res_t r;
    int cnt = 0, sx = 0, sy = 0, mnx = 63, mxx = 0, mny = 63, mxy = 0;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        int i = y * 40 + x;
        bit nb;
        bit hit;
        nb = (x > 0 && m[i-1] == 1'b1) || (x < 39 && m[i+1] == 1'b1) ||
             (y > 0 && m[i-40] == 1'b1) || (y < 29 && m[i+40] == 1'b1);
        hit = (m[i] == 1'b1) && (!Filt || nb);
        if (hit) begin
          cnt++;
          sx += x;
          sy += y;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
      end
    end
    r.valid = (cnt != 0);
    r.count = 11'(cnt);
    r.sum_x = 16'(sx);
    r.sum_y = 16'(sy);
    if (cnt == 0) begin
      r.min_x = '0; r.max_x = '0; r.min_y = '0; r.max_y = '0;
    end else begin
      r.min_x = 6'(mnx); r.max_x = 6'(mxx); r.min_y = 6'(mny); r.max_y = 6'(mxy);
    end
    return r;
  endfunction

  // Timing model: edges elapsed since the accepting edge, -1 when idle.
  int            phase = -1;
  logic [1199:0] snap = '0;
  res_t          m_res = '0;
  bit            m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase  = -1;
      m_res  = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (phase < 0) begin
        if (start) begin
          phase = 0;
          snap  = frame;
        end
      end else begin
        phase++;
        if (phase == 1201) begin
          m_res  = compute(snap);
          m_done = 1'b1;
          phase  = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      res_t got;
      got = {valid, count, min_x, max_x, min_y, max_y, sum_x, sum_y};
      n_checks++;
      if (busy !== (phase >= 0) || done !== m_done || got !== m_res) begin
        n_errors++;
        if (n_errors < 30)
          $display("FAIL cycle %0d: busy/done %b%b res %h required %b%b res %h", cyc, busy,
                   done, got, phase >= 0, m_done, m_res);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input res_t exp);
    check({name, " count"}, 64'(count), 64'(exp.count));
    check({name, " valid"}, 64'(valid), 64'(exp.valid));
    check({name, " box"}, 64'({min_x, max_x, min_y, max_y}),
          64'({exp.min_x, exp.max_x, exp.min_y, exp.max_y}));
    check({name, " sums"}, 64'({sum_x, sum_y}), 64'({exp.sum_x, exp.sum_y}));
  endtask

  // Start a scan from idle and wait for oDone; lat = edges from accept to publish.
  task automatic do_scan(input logic [1199:0] m, output int lat);
    int n;
    @(negedge clk);
    frame = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 1400) begin
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    if (done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL scan timeout: no oDone after %0d edges", lat);
    end
  endtask

  function automatic logic [1199:0] rand_map(input int dens);
    logic [1199:0] m;
    for (int i = 0; i < 1200; i++) m[i] = ($urandom_range(0, 99) < dens);
    return m;
  endfunction

  initial begin
    logic [1199:0] ones;
    logic [1199:0] m;
    res_t          lit;
    int            lat;
    int            dones;
    int            t1;
    ones = '1;

    repeat (3) @(negedge clk);
    check_res("reset", '0);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_scan('0, lat);
    check("empty latency", 64'(lat), 64'd1201);
    check_res("empty", '0);

    do_scan(ones, lat);
    check("full latency", 64'(lat), 64'd1201);
    lit = '{valid: 1'b1, count: 11'd1200, min_x: 6'd0, max_x: 6'd39, min_y: 6'd0,
            max_y: 6'd29, sum_x: 16'd23400, sum_y: 16'd17400};
    check_res("full", lit);

    m = '0;
    m[41] = 1'b1;
    m[42] = 1'b1;
    do_scan(m, lat);
    lit = '{valid: 1'b1, count: 11'd2, min_x: 6'd1, max_x: 6'd2, min_y: 6'd1,
            max_y: 6'd1, sum_x: 16'd3, sum_y: 16'd2};
    check_res("two-patch", lit);

    m = '0;
    m[1199] = 1'b1;
    do_scan(m, lat);
    if (Filt) lit = '0;
    else lit = '{valid: 1'b1, count: 11'd1, min_x: 6'd39, max_x: 6'd39, min_y: 6'd29,
                 max_y: 6'd29, sum_x: 16'd39, sum_y: 16'd29};
    check_res("isolated", lit);

    for (int k = 0; k < 6; k++) begin
      m = rand_map($urandom_range(1, 60));
      do_scan(m, lat);
      check("random latency", 64'(lat), 64'd1201);
      check_res("random", compute(m));
    end

    // Re-pulse mid-scan: must be ignored, exactly one oDone.
    @(negedge clk);
    frame = rand_map(30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 1400; i++) begin
      if (i == 300) start = 1'b1;
      if (i == 301) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("repulse dones", 64'(dones), 64'd1);

    // Reset at E600 discards the scan.
    @(negedge clk);
    frame = rand_map(40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (599) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_res("mid reset", '0);
    check("mid reset busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("mid reset dones", 64'(dones), 64'd0);

    m = rand_map(50);
    do_scan(m, lat);
    check("post-reset latency", 64'(lat), 64'd1201);
    check_res("post-reset", compute(m));

    // Frame swapped to all-ones at E10 must not leak into the scan.
    @(negedge clk);
    frame = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    frame = ones;
    lat = 10;
    while (done !== 1'b1 && lat < 1400) begin
      @(negedge clk);
      lat++;
    end
    check("swap done seen", 64'(done), 64'd1);
    check("swap count", 64'(count), 64'd0);

    // Held start re-triggers every 1202 cycles.
    @(negedge clk);
    frame = rand_map(20);
    start = 1'b1;
    dones = 0;
    t1 = 0;
    lat = 0;
    for (int i = 0; i < 3000 && dones < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) t1 = cyc;
        else lat = cyc - t1;
      end
    end
    start = 1'b0;
    check("held dones", 64'(dones), 64'd2);
    check("held period", 64'(lat), 64'd1202);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
